// File: rtl/aes_pkg.sv
// Shared AES-128 constants: widths, round count, FSM encoding, Rcon and the forward S-box.
package aes_pkg;

   localparam int KEY_W  = 128;
   localparam int WORD_W = 32;
   localparam int AES_NR = 10;

   typedef enum logic {
      IDLE   = 1'b0,
      EXPAND = 1'b1
   } state_t;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Round constant for the round being produced, 1..10.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] c;
      c = 8'h00;
      case (r)
         4'd1:    c = 8'h01;
         4'd2:    c = 8'h02;
         4'd3:    c = 8'h04;
         4'd4:    c = 8'h08;
         4'd5:    c = 8'h10;
         4'd6:    c = 8'h20;
         4'd7:    c = 8'h40;
         4'd8:    c = 8'h80;
         4'd9:    c = 8'h1b;
         4'd10:   c = 8'h36;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/aes_subword.sv
// 32-bit combinational SubWord: four forward S-box lookups, one per byte.
module aes_subword
   import aes_pkg::*;
(
   input  logic [WORD_W-1:0] din,
   output logic [WORD_W-1:0] dout
);

   for (genvar i = 0; i < WORD_W / 8; i++) begin : g_sbox
      assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
   end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule, one round key per clock.
// Optional key store with indexed readback when AES_KEY_READBACK_EN is defined.
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int NR = AES_NR
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [KEY_W-1:0] key_in,
   output logic             busy,
   output logic             rk_valid,
   output logic [3:0]       rk_round,
   output logic [KEY_W-1:0] rk_out,
   output logic             done
`ifdef AES_KEY_READBACK_EN
   ,
   input  logic [3:0]       rd_idx,
   output logic [KEY_W-1:0] rd_key
`endif
);

   localparam logic [3:0] LAST = 4'(NR);

   state_t            state, state_nxt;
   logic [WORD_W-1:0] w0, w1, w2, w3, rot, sub, t;
   logic [WORD_W-1:0] n0, n1, n2, n3;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = EXPAND;
         EXPAND:  if (rk_round == LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign {w0, w1, w2, w3} = rk_out;
   assign rot = {w3[23:0], w3[31:24]};

   aes_subword u_subword (
      .din  (rot),
      .dout (sub)
   );

   assign t  = sub ^ {rcon(rk_round + 4'd1), 24'h0};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rk_out   <= '0;
         rk_round <= '0;
      end else if (state == IDLE && start) begin
         rk_out   <= key_in;
         rk_round <= '0;
      end else if (state == EXPAND && rk_round != LAST) begin
         rk_out   <= {n0, n1, n2, n3};
         rk_round <= rk_round + 4'd1;
      end
   end

   assign busy     = (state == EXPAND);
   assign rk_valid = busy;
   assign done     = busy && (rk_round == LAST);

`ifdef AES_KEY_READBACK_EN
   logic [KEY_W-1:0] key_store [0:AES_NR];

   // NOTE: the store is small and must read back 0 after reset, so it is cleared explicitly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i <= AES_NR; i++) key_store[i] <= '0;
      end else if (rk_valid) begin
         key_store[rk_round] <= rk_out;
      end
   end

   assign rd_key = (rd_idx <= LAST) ? key_store[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 and all-zero key schedules, ignored start,
// mid-run reset, back-to-back restarts, and key-store readback under AES_KEY_READBACK_EN.
module tb_aes_key_expand;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [127:0] key_in;
   logic         busy, rk_valid, done;
   logic [3:0]   rk_round;
   logic [127:0] rk_out;
`ifdef AES_KEY_READBACK_EN
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   aes_key_expand dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .key_in   (key_in),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_round (rk_round),
      .rk_out   (rk_out),
      .done     (done)
`ifdef AES_KEY_READBACK_EN
      ,
      .rd_idx   (rd_idx),
      .rd_key   (rd_key)
`endif
   );

   typedef struct {
      logic [127:0] key;
      int           rnd;
      logic [127:0] exp;
   } vec_t;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   logic [127:0] fips [0:10];
   vec_t         vecs [13];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 20) begin
         tick();
         n++;
      end
      check("wait_idle", {127'b0, busy}, 128'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone;
      int pos;

      fips[0]  = FIPS_KEY;
      fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
      fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      for (int i = 0; i <= 10; i++) vecs[i] = '{FIPS_KEY, i, fips[i]};
      vecs[11] = '{128'h0, 1,  128'h62636363626363636263636362636363};
      vecs[12] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

      rst_n  = 1'b0;
      start  = 1'b0;
      key_in = '0;
`ifdef AES_KEY_READBACK_EN
      rd_idx = 4'd0;
`endif
      repeat (3) tick();
      check("reset_busy",     {127'b0, busy},     128'd0);
      check("reset_rk_valid", {127'b0, rk_valid}, 128'd0);
      check("reset_rk_round", {124'b0, rk_round}, 128'd0);
      check("reset_rk_out",   rk_out,             128'd0);
      check("reset_done",     {127'b0, done},     128'd0);
`ifdef AES_KEY_READBACK_EN
      check("reset_rd_key",   rd_key,             128'd0);
`endif
      rst_n = 1'b1;
      tick();

      // Table: start an expansion, advance to the target round, compare.
      for (int i = 0; i < 13; i++) begin
         wait_idle();
         key_in = vecs[i].key;
         start  = 1'b1;
         tick();
         start  = 1'b0;
         repeat (vecs[i].rnd) tick();
         check($sformatf("vec%0d_rk_round", i), {124'b0, rk_round}, 128'(vecs[i].rnd));
         check($sformatf("vec%0d_rk_out", i),   rk_out,             vecs[i].exp);
         check($sformatf("vec%0d_rk_valid", i), {127'b0, rk_valid}, 128'd1);
         check($sformatf("vec%0d_done", i),     {127'b0, done},     128'(vecs[i].rnd == 10));
      end

      // Start pulsed in cycles T+3 and T+11 of a running expansion is ignored.
      wait_idle();
      key_in = FIPS_KEY;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      ndone  = 0;
      for (int c = 1; c <= 11; c++) begin
         check($sformatf("ign_c%0d_rk_out", c), rk_out, fips[c-1]);
         check($sformatf("ign_c%0d_busy", c), {127'b0, busy}, 128'd1);
         if (done === 1'b1) ndone++;
         key_in = 128'h0;
         start  = (c == 3 || c == 11);
         tick();
      end
      start = 1'b0;
      for (int c = 12; c <= 15; c++) begin
         check($sformatf("ign_c%0d_busy", c), {127'b0, busy}, 128'd0);
         if (done === 1'b1) ndone++;
         tick();
      end
      check("ign_done_count", 128'(ndone), 128'd1);

`ifdef AES_KEY_READBACK_EN
      rd_idx = 4'd1;
      #1 check("rd_idx1", rd_key, fips[1]);
      rd_idx = 4'd10;
      #1 check("rd_idx10", rd_key, fips[10]);
      rd_idx = 4'd15;
      #1 check("rd_idx15", rd_key, 128'd0);
      rd_idx = 4'd0;
      #1 check("rd_idx0", rd_key, FIPS_KEY);
`endif

      // Reset mid-expansion at round 5, then a fresh start.
      key_in = FIPS_KEY;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      repeat (5) tick();
      check("mid_rk_round5", {124'b0, rk_round}, 128'd5);
      rst_n = 1'b0;
      tick();
      check("mid_rst_busy",     {127'b0, busy},     128'd0);
      check("mid_rst_rk_valid", {127'b0, rk_valid}, 128'd0);
      check("mid_rst_rk_round", {124'b0, rk_round}, 128'd0);
      check("mid_rst_rk_out",   rk_out,             128'd0);
      check("mid_rst_done",     {127'b0, done},     128'd0);
      rst_n = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("after_rst_rk_valid", {127'b0, rk_valid}, 128'd1);
      check("after_rst_rk_round", {124'b0, rk_round}, 128'd0);
      check("after_rst_rk_out",   rk_out,             FIPS_KEY);
      wait_idle();

      // Reset and start together: reset wins.
      rst_n = 1'b0;
      start = 1'b1;
      tick();
      check("rst_start_busy", {127'b0, busy}, 128'd0);
      start = 1'b0;
      rst_n = 1'b1;
      tick();

      // Start held high for 30 cycles: restart every 12 cycles.
      key_in = FIPS_KEY;
      start  = 1'b1;
      ndone  = 0;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (c <= 24) begin
            pos = (c - 1) % 12;
            check($sformatf("b2b_c%0d_valid", c), {127'b0, rk_valid}, 128'(pos < 11));
            if (pos < 11) begin
               check($sformatf("b2b_c%0d_round", c), {124'b0, rk_round}, 128'(pos));
               check($sformatf("b2b_c%0d_rk_out", c), rk_out, fips[pos]);
            end
            if (done === 1'b1) ndone++;
         end
      end
      check("b2b_done_count", 128'(ndone), 128'd2);
      start = 1'b0;
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
